// File: rtl/flux_sched_pkg.sv
// Shared types and helpers for the FLUX round-robin scheduler and its rotating picker.
package flux_sched_pkg;

    typedef enum logic {IDLE, BURST} sched_state_t;

    function automatic int unsigned tag_width(input int unsigned flux);
        return (flux > 1) ? $clog2(flux) : 1;
    endfunction

    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned flux);
        return (ptr + 1 >= flux) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/read_interface.sv
// Bundle of per-flux read FIFO handshakes feeding a multi-flux actor.
interface read_interface #(
    parameter int unsigned FLUX       = 2,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [FLUX-1:0]       empty;
    logic [FLUX-1:0]       read;
    logic [DATA_WIDTH-1:0] dout;

    modport actor (input empty, input dout, output read);
    modport fifo  (output empty, output dout, input read);
endinterface

// File: rtl/write_interface.sv
// Write handshake into a single downstream FIFO.
interface write_interface #(
    parameter int unsigned WIDTH = 9
);
    logic             full;
    logic             write;
    logic [WIDTH-1:0] din;

    modport actor (input full, output write, output din);
    modport fifo  (output full, input write, input din);
endinterface

// File: rtl/rr_picker.sv
// Combinational rotating priority encoder: first set req bit at or after ptr, wrapping.
module rr_picker #(
    parameter int unsigned FLUX      = 2,
    parameter int unsigned TAG_WIDTH = 1
) (
    input  logic [FLUX-1:0]      req,
    input  logic [TAG_WIDTH-1:0] ptr,
    output logic                 found,
    output logic [TAG_WIDTH-1:0] idx
);
    localparam logic [TAG_WIDTH:0] FLUX_W = (TAG_WIDTH + 1)'(FLUX);

    logic [2*FLUX-1:0]    dbl;
    logic [FLUX-1:0]      rot;
    logic [TAG_WIDTH-1:0] off;
    logic [TAG_WIDTH:0]   sum;

    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[FLUX-1:0];
        found = 1'b0;
        off   = '0;
        // Scan farthest-first so the offset nearest ptr is the one that sticks.
        for (int k = FLUX - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = TAG_WIDTH'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= FLUX_W) begin
            sum = sum - FLUX_W;
        end
        idx = sum[TAG_WIDTH-1:0];
    end
endmodule

// File: rtl/flux_rr_scheduler.sv
// Round-robin burst scheduler merging FLUX token FIFOs into one tagged downstream FIFO.
module flux_rr_scheduler
    import flux_sched_pkg::*;
#(
    parameter int unsigned FLUX       = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned QW         = 4,
    localparam int unsigned TAG_WIDTH = tag_width(FLUX)
) (
    input  logic                 clk,
    input  logic                 rst,
    read_interface.actor         read_port,
    write_interface.actor        write_port,
    input  logic [QW-1:0]        cfg_quantum,
    output logic                 grant_valid,
    output logic [TAG_WIDTH-1:0] grant_tag
);
    localparam logic [QW:0] CNT_ONE = (QW + 1)'(1);

    sched_state_t         state;
    logic [TAG_WIDTH-1:0] rr_ptr;
    logic [TAG_WIDTH-1:0] tag;
    logic [QW:0]          cnt;
    logic [QW:0]          q;
    logic                 cool;

    logic                 pick_found;
    logic [TAG_WIDTH-1:0] pick_idx;
    logic [TAG_WIDTH-1:0] cur;
    logic [QW:0]          q_start;
    logic                 avail;
    logic                 xfer;
    logic                 done;

    rr_picker #(
        .FLUX      (FLUX),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_picker (
        .req   (~read_port.empty),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign grant_tag = tag;

    always_comb begin
        q_start = (cfg_quantum == '0) ? CNT_ONE : {1'b0, cfg_quantum};
        cur     = (state == IDLE) ? pick_idx : tag;
        // cool marks the dead cycle right after a release: no arbitration then.
        avail   = (state == IDLE) ? (pick_found && !cool) : !read_port.empty[tag];
        xfer    = !rst && avail && !write_port.full;

        read_port.read = '0;
        if (xfer) begin
            read_port.read[cur] = 1'b1;
        end
        write_port.write = xfer;
        write_port.din   = xfer ? {cur, read_port.dout} : 'x;

        if (state == IDLE) begin
            done = xfer && (q_start == CNT_ONE);
        end else begin
            done = !write_port.full && (read_port.empty[tag] || (cnt + CNT_ONE == q));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            tag         <= '0;
            cnt         <= '0;
            q           <= '0;
            cool        <= 1'b0;
            grant_valid <= 1'b0;
        end else begin
            cool <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_found && !cool) begin
                        tag         <= pick_idx;
                        q           <= q_start;
                        cnt         <= write_port.full ? '0 : CNT_ONE;
                        state       <= BURST;
                        grant_valid <= 1'b1;
                    end
                end
                BURST: begin
                    if (xfer) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (done) begin
                state       <= IDLE;
                grant_valid <= 1'b0;
                rr_ptr      <= TAG_WIDTH'(rr_next(32'(cur), FLUX));
                cool        <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_flux_rr_scheduler.sv
// Directed table-driven bench for flux_rr_scheduler (FLUX=2 and FLUX=4 instances).
module tb_flux_rr_scheduler;

    typedef struct {
        bit rst;
        bit full;
        int cfgq;
        bit w;
        int tag;
        bit gv;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       full;
    logic [3:0] cfg_quantum;
    logic       gv2;
    logic       gt2;
    logic       gv4;
    logic [1:0] gt4;

    int   avail2[2];
    int   head2[2];
    int   avail4[4];
    int   head4[4];
    int   expseq[4];
    bit   use4;
    int   checks;
    int   failures;
    vec_t tbl[$];

    read_interface #(.FLUX(2), .DATA_WIDTH(8)) rif2 ();
    write_interface #(.WIDTH(9)) wif2 ();
    read_interface #(.FLUX(4), .DATA_WIDTH(8)) rif4 ();
    write_interface #(.WIDTH(10)) wif4 ();

    flux_rr_scheduler #(.FLUX(2), .DATA_WIDTH(8), .QW(4)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .read_port   (rif2),
        .write_port  (wif2),
        .cfg_quantum (cfg_quantum),
        .grant_valid (gv2),
        .grant_tag   (gt2)
    );

    flux_rr_scheduler #(.FLUX(4), .DATA_WIDTH(8), .QW(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .read_port   (rif4),
        .write_port  (wif4),
        .cfg_quantum (cfg_quantum),
        .grant_valid (gv4),
        .grant_tag   (gt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign wif2.full = full;
    assign wif4.full = full;

    // Upstream FIFO models: token k of flux f carries f*64+k.
    always_comb begin
        for (int i = 0; i < 2; i++) rif2.empty[i] = (avail2[i] == 0);
        rif2.dout = '0;
        for (int i = 0; i < 2; i++) if (rif2.read[i]) rif2.dout = 8'(i * 64 + head2[i]);
        for (int i = 0; i < 4; i++) rif4.empty[i] = (avail4[i] == 0);
        rif4.dout = '0;
        for (int i = 0; i < 4; i++) if (rif4.read[i]) rif4.dout = 8'(i * 64 + head4[i]);
    end

    function automatic vec_t mk(bit r, bit f, int q, bit w, int tag, bit g);
        vec_t v;
        v.rst = r; v.full = f; v.cfgq = q; v.w = w; v.tag = tag; v.gv = g;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n, input int q);
        for (int i = 0; i < n; i++) tbl.push_back(mk(0, 0, q, 0, 0, 0));
    endtask

    task automatic load2(input int a, input int b);
        avail2[0] = a; avail2[1] = b;
        for (int i = 0; i < 2; i++) head2[i] = 0;
        for (int i = 0; i < 4; i++) expseq[i] = 0;
    endtask

    task automatic load4(input int a, input int b, input int c, input int d);
        avail4[0] = a; avail4[1] = b; avail4[2] = c; avail4[3] = d;
        for (int i = 0; i < 4; i++) head4[i] = 0;
        for (int i = 0; i < 4; i++) expseq[i] = 0;
    endtask

    // Each vector starts 1 time unit after a posedge; outputs sampled at the negedge.
    task automatic run_tbl(input string tname);
        int w, rd, tg, dat, g, gt;
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            rst = v.rst;
            full = v.full;
            cfg_quantum = 4'(v.cfgq);
            #4;
            if (use4) begin
                w = int'(wif4.write); rd = int'(rif4.read);
                tg = int'(wif4.din[9:8]); dat = int'(wif4.din[7:0]);
                g = int'(gv4); gt = int'(gt4);
            end else begin
                w = int'(wif2.write); rd = int'(rif2.read);
                tg = int'(wif2.din[8]); dat = int'(wif2.din[7:0]);
                g = int'(gv2); gt = int'(gt2);
            end
            chk($sformatf("%s[%0d].write", tname, i), w, int'(v.w));
            chk($sformatf("%s[%0d].read", tname, i), rd, v.w ? (1 << v.tag) : 0);
            chk($sformatf("%s[%0d].grant_valid", tname, i), g, int'(v.gv));
            if (v.gv) chk($sformatf("%s[%0d].grant_tag", tname, i), gt, v.tag);
            if (v.w) begin
                chk($sformatf("%s[%0d].din_tag", tname, i), tg, v.tag);
                chk($sformatf("%s[%0d].din_data", tname, i), dat, v.tag * 64 + expseq[v.tag]);
                expseq[v.tag]++;
            end
            @(posedge clk);
            #1;
            for (int f = 0; f < 4; f++) begin
                if (rd[f]) begin
                    if (use4) begin
                        avail4[f]--; head4[f]++;
                    end else if (f < 2) begin
                        avail2[f]--; head2[f]++;
                    end
                end
            end
        end
        tbl.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; use4 = 1'b0;
        rst = 1'b1; full = 1'b0; cfg_quantum = 4'd1;
        load2(0, 0);
        load4(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        tbl.push_back(mk(1, 0, 1, 0, 0, 0));
        run_tbl("reset");
        chk("reset.grant_tag2", int'(gt2), 0);
        chk("reset.grant_valid4", int'(gv4), 0);
        chk("reset.grant_tag4", int'(gt4), 0);

        // q=1, 4+4 tokens: alternating tags, one token every 2 cycles
        load2(4, 4);
        for (int k = 0; k < 16; k++) tbl.push_back(mk(0, 0, 1, (k % 2) == 0, (k / 2) % 2, 0));
        idle(2, 1);
        run_tbl("q1_alt");
        chk("q1_alt.left0", avail2[0], 0);
        chk("q1_alt.left1", avail2[1], 0);

        // q=3, 6+6 tokens: bursts of three with a dead cycle at each switch
        load2(6, 6);
        for (int k = 0; k < 16; k++)
            tbl.push_back(mk(0, 0, 3, (k % 4) != 3, (k / 4) % 2, (k % 4) == 1 || (k % 4) == 2));
        idle(2, 3);
        run_tbl("q3_burst");
        chk("q3_burst.left0", avail2[0], 0);
        chk("q3_burst.left1", avail2[1], 0);

        // q=4, 2+5 tokens: early release on empty, then 4, then the last one
        load2(2, 5);
        tbl.push_back(mk(0, 0, 4, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4, 1, 0, 1));
        tbl.push_back(mk(0, 0, 4, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4, 1, 1, 0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, 4, 1, 1, 1));
        tbl.push_back(mk(0, 0, 4, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4, 1, 1, 0));
        tbl.push_back(mk(0, 0, 4, 0, 1, 1));
        tbl.push_back(mk(0, 0, 4, 0, 0, 0));
        idle(1, 4);
        run_tbl("q4_short");
        // rr_ptr must be back at 0: with both fluxes ready, flux0 wins
        load2(1, 1);
        tbl.push_back(mk(0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0));
        run_tbl("q4_ptr");

        // Full for 5 cycles after 1 of 3 tokens; mid-burst quantum change ignored
        load2(3, 0);
        tbl.push_back(mk(0, 0, 3, 1, 0, 0));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(0, 1, (k < 2) ? 3 : 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0));
        idle(2, 1);
        run_tbl("full_stall");
        chk("full_stall.left0", avail2[0], 0);

        // Reset mid-burst at cnt=2 (rr_ptr=1 beforehand, so flux1 is picked first)
        load2(3, 6);
        tbl.push_back(mk(0, 0, 4, 1, 1, 0));
        tbl.push_back(mk(0, 0, 4, 1, 1, 1));
        tbl.push_back(mk(1, 0, 4, 0, 1, 1));
        run_tbl("rst_burst");
        chk("rst_burst.left0", avail2[0], 3);
        chk("rst_burst.left1", avail2[1], 4);
        chk("rst_burst.grant_valid", int'(gv2), 0);
        tbl.push_back(mk(0, 0, 4, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4, 1, 0, 1));
        tbl.push_back(mk(0, 0, 4, 1, 0, 1));
        tbl.push_back(mk(0, 0, 4, 0, 0, 1));
        tbl.push_back(mk(0, 0, 4, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4, 1, 1, 0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, 4, 1, 1, 1));
        tbl.push_back(mk(0, 0, 4, 0, 0, 0));
        idle(1, 4);
        run_tbl("rst_after");
        chk("rst_after.left0", avail2[0], 0);
        chk("rst_after.left1", avail2[1], 0);

        // FLUX=4, cfg_quantum=0 acts as 1; only flux2 busy
        use4 = 1'b1;
        load4(0, 0, 3, 0);
        for (int k = 0; k < 6; k++) tbl.push_back(mk(0, 0, 0, (k % 2) == 0, 2, 0));
        idle(1, 0);
        run_tbl("q0_flux2");
        chk("q0_flux2.left2", avail4[2], 0);
        // rr_ptr must be 3: flux3 beats flux0
        load4(1, 0, 0, 1);
        tbl.push_back(mk(0, 0, 0, 1, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0));
        idle(1, 0);
        run_tbl("q0_ptr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
